// File: rtl/core_seq_pkg.sv
// Shared constants, state encoding and inst bit map for the systolic-core
// instruction sequencer.
package core_seq_pkg;

  // Array and feature-map geometry.
  localparam int unsigned ROW      = 8;
  localparam int unsigned COL      = 8;
  localparam int unsigned IN_W     = 6;
  localparam int unsigned K        = 3;
  localparam int unsigned LEN_NIJ  = IN_W * IN_W;
  localparam int unsigned LEN_KIJ  = K * K;
  localparam int unsigned O_W      = IN_W - K + 1;
  localparam int unsigned LEN_ONIJ = O_W * O_W;
  localparam int unsigned EXE_CYC  = LEN_NIJ + ROW + COL;
  localparam int unsigned W_BASE   = 32'h400;
  localparam int unsigned GAP_CYC  = 4;
  localparam int unsigned RST_CYC  = 2;

  // Bus and counter widths.
  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned INST_W  = 35;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned KIJ_W   = 4;
  localparam int unsigned ONIJ_W  = 5;
  localparam int unsigned POS_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 4'd0,
    CLR     = 4'd1,
    WL0     = 4'd2,
    GAP     = 4'd3,
    WPE     = 4'd4,
    AL0     = 4'd5,
    EXE     = 4'd6,
    DRN     = 4'd7,
    ACC_RST = 4'd8,
    ACC_RD  = 4'd9,
    ACC_OUT = 4'd10,
    FIN     = 4'd11
  } seq_state_e;

  // inst field positions.
  localparam int unsigned B_ZERO      = 34;
  localparam int unsigned B_ACC       = 33;
  localparam int unsigned B_CEN_P     = 32;
  localparam int unsigned B_WEN_P     = 31;
  localparam int unsigned B_A_PMEM    = 20;
  localparam int unsigned B_CEN_X     = 19;
  localparam int unsigned B_WEN_X     = 18;
  localparam int unsigned B_A_XMEM    = 7;
  localparam int unsigned B_OFIFO_RD  = 6;
  localparam int unsigned B_IFIFO_WR  = 5;
  localparam int unsigned B_IFIFO_RD  = 4;
  localparam int unsigned B_L0_RD     = 3;
  localparam int unsigned B_L0_WR     = 2;
  localparam int unsigned B_EXECUTE   = 1;
  localparam int unsigned B_LOAD      = 0;

  // Both memories deselected, everything else low.
  localparam logic [INST_W-1:0] INST_IDLE =
      (INST_W'(1) << B_CEN_P) | (INST_W'(1) << B_WEN_P) |
      (INST_W'(1) << B_CEN_X) | (INST_W'(1) << B_WEN_X);

endpackage

// File: rtl/core_inst_sequencer_if.sv
// Sequencer <-> core bus: instruction word, core reset and OFIFO valid.
//   master (sequencer): drives inst, core_rst; samples valid
//   slave  (core)     : samples inst, core_rst; drives valid
interface core_inst_sequencer_if;
  logic [core_seq_pkg::INST_W-1:0] inst;
  logic                            core_rst;
  logic                            valid;

  modport master (output inst, output core_rst, input valid);
  modport slave  (input inst, input core_rst, output valid);
endinterface

// File: rtl/seq_acc_addr_gen.sv
// pmem read address for the accumulation phase, built from incremental
// output row/col and kernel row/col counters instead of divide/modulo.
//   clk, reset      : clock, synchronous active-high reset
//   o_clr, o_step   : restart / advance the output pixel (onij) position
//   k_clr, k_step   : restart / advance the kernel tap (kij) position
//   addr_c          : combinational address for the current (onij, kij)
module seq_acc_addr_gen
  import core_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              o_clr,
  input  logic              o_step,
  input  logic              k_clr,
  input  logic              k_step,
  output logic [ADDR_W-1:0] addr_c
);

  logic [POS_W-1:0]  orow_q, orow_d, ocol_q, ocol_d;
  logic [POS_W-1:0]  krow_q, krow_d, kcol_q, kcol_d;
  logic [ADDR_W-1:0] kbase_q, kbase_d;

  // Row/col counters wrap at their widths; kbase tracks kij*len_nij.
  always_comb begin
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    krow_d  = krow_q;
    kcol_d  = kcol_q;
    kbase_d = kbase_q;
    if (o_clr) begin
      orow_d = '0;
      ocol_d = '0;
    end else if (o_step) begin
      if (ocol_q == POS_W'(O_W - 1)) begin
        ocol_d = '0;
        orow_d = orow_q + POS_W'(1);
      end else begin
        ocol_d = ocol_q + POS_W'(1);
      end
    end
    if (k_clr) begin
      krow_d  = '0;
      kcol_d  = '0;
      kbase_d = '0;
    end else if (k_step) begin
      kbase_d = kbase_q + ADDR_W'(LEN_NIJ);
      if (kcol_q == POS_W'(K - 1)) begin
        kcol_d = '0;
        krow_d = krow_q + POS_W'(1);
      end else begin
        kcol_d = kcol_q + POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      orow_q  <= '0;
      ocol_q  <= '0;
      krow_q  <= '0;
      kcol_q  <= '0;
      kbase_q <= '0;
    end else begin
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      krow_q  <= krow_d;
      kcol_q  <= kcol_d;
      kbase_q <= kbase_d;
    end
  end

  assign addr_c = kbase_q
                + (ADDR_W'(orow_q) + ADDR_W'(krow_q)) * ADDR_W'(IN_W)
                + ADDR_W'(ocol_q) + ADDR_W'(kcol_q);

endmodule

// File: rtl/core_inst_sequencer.sv
// Drives the systolic core through a full convolution: per-kij weight load,
// activation load, execute, OFIFO drain to pmem, then per-pixel accumulation.
//   clk, reset   : clock, synchronous active-high reset (aborts a run)
//   start        : 1-cycle pulse accepted only in IDLE
//   core_if      : master side of inst / core_rst / valid bus
//   out_valid    : accumulated pixel ready, index on out_idx
//   busy, done   : run in progress / 1-cycle end-of-run pulse
//   perf_cycles  : busy-cycle counter, present when SEQ_PERF_CNT_EN is defined
module core_inst_sequencer
  import core_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  core_inst_sequencer_if.master core_if,
  output logic                  out_valid,
  output logic [ONIJ_W-1:0]     out_idx,
  output logic                  busy,
  output logic                  done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  localparam logic [STATE_W-1:0] S_IDLE    = STATE_W'(IDLE);
  localparam logic [STATE_W-1:0] S_CLR     = STATE_W'(CLR);
  localparam logic [STATE_W-1:0] S_WL0     = STATE_W'(WL0);
  localparam logic [STATE_W-1:0] S_GAP     = STATE_W'(GAP);
  localparam logic [STATE_W-1:0] S_WPE     = STATE_W'(WPE);
  localparam logic [STATE_W-1:0] S_AL0     = STATE_W'(AL0);
  localparam logic [STATE_W-1:0] S_EXE     = STATE_W'(EXE);
  localparam logic [STATE_W-1:0] S_DRN     = STATE_W'(DRN);
  localparam logic [STATE_W-1:0] S_ACC_RST = STATE_W'(ACC_RST);
  localparam logic [STATE_W-1:0] S_ACC_RD  = STATE_W'(ACC_RD);
  localparam logic [STATE_W-1:0] S_ACC_OUT = STATE_W'(ACC_OUT);
  localparam logic [STATE_W-1:0] S_FIN     = STATE_W'(FIN);

  // Elaboration-time guard: 11-bit addresses must never wrap.
  if (LEN_KIJ * LEN_NIJ > (1 << ADDR_W)) begin : g_pmem_range
    $fatal(1, "psum region exceeds pmem address space");
  end
  if (W_BASE + LEN_KIJ * COL > (1 << ADDR_W)) begin : g_xmem_range
    $fatal(1, "weight region exceeds xmem address space");
  end

  logic [STATE_W-1:0] state_q, state_d, ret_q, ret_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KIJ_W-1:0]   kij_q, kij_d;
  logic [ONIJ_W-1:0]  o_q, o_d;
  logic               acc_pend_q, acc_pend_d;
  logic [INST_W-1:0]  inst_q, inst_d;
  logic               core_rst_q, core_rst_d;
  logic               out_valid_q, out_valid_d;
  logic [ONIJ_W-1:0]  out_idx_q, out_idx_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               start_acc_c, o_clr, o_step, k_clr, k_step;
  logic [ADDR_W-1:0]  acc_addr_c;

  assign start_acc_c = (state_q == S_IDLE) && start;

  seq_acc_addr_gen u_acc_addr (
    .clk    (clk),
    .reset  (reset),
    .o_clr  (o_clr),
    .o_step (o_step),
    .k_clr  (k_clr),
    .k_step (k_step),
    .addr_c (acc_addr_c)
  );

  // Next state and phase counters. GAP returns to ret_q.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q + CNT_W'(1);
    kij_d   = kij_q;
    o_d     = o_q;
    o_clr   = 1'b0;
    o_step  = 1'b0;
    k_clr   = 1'b0;
    k_step  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_CLR;
          kij_d   = '0;
          o_d     = '0;
          o_clr   = 1'b1;
        end
      end
      S_CLR: if (cnt_q == CNT_W'(RST_CYC - 1)) begin
        state_d = S_WL0;
        cnt_d   = '0;
      end
      S_WL0: if (cnt_q == CNT_W'(COL - 1)) begin
        state_d = S_GAP;
        ret_d   = S_WPE;
        cnt_d   = '0;
      end
      S_GAP: if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
        state_d = ret_q;
        cnt_d   = '0;
      end
      S_WPE: if (cnt_q == CNT_W'(COL - 1)) begin
        state_d = S_GAP;
        ret_d   = S_AL0;
        cnt_d   = '0;
      end
      S_AL0: if (cnt_q == CNT_W'(LEN_NIJ - 1)) begin
        state_d = S_GAP;
        ret_d   = S_EXE;
        cnt_d   = '0;
      end
      S_EXE: if (cnt_q == CNT_W'(EXE_CYC - 1)) begin
        state_d = S_DRN;
        cnt_d   = '0;
      end
      S_DRN: begin
        // cnt counts pmem writes; it only moves when the OFIFO has data.
        cnt_d = cnt_q;
        if (core_if.valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LEN_NIJ - 1)) begin
            state_d = S_GAP;
            cnt_d   = '0;
            if (kij_q == KIJ_W'(LEN_KIJ - 1)) begin
              ret_d = S_ACC_RST;
            end else begin
              ret_d = S_CLR;
              kij_d = kij_q + KIJ_W'(1);
            end
          end
        end
      end
      S_ACC_RST: begin
        state_d = S_ACC_RD;
        cnt_d   = '0;
        k_clr   = 1'b1;
      end
      S_ACC_RD: begin
        k_step = 1'b1;
        if (cnt_q == CNT_W'(LEN_KIJ - 1)) begin
          state_d = S_ACC_OUT;
          cnt_d   = '0;
        end
      end
      S_ACC_OUT: if (cnt_q == CNT_W'(1)) begin
        o_step = 1'b1;
        cnt_d  = '0;
        if (o_q == ONIJ_W'(LEN_ONIJ - 1)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_ACC_RST;
          o_d     = o_q + ONIJ_W'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode of the current state; registered so each field follows
  // its state by one cycle. acc trails each pmem read by one cycle.
  always_comb begin
    inst_d              = INST_IDLE;
    inst_d[B_ZERO]      = 1'b0;
    inst_d[B_IFIFO_WR]  = 1'b0;
    inst_d[B_IFIFO_RD]  = 1'b0;
    inst_d[B_ACC]       = acc_pend_q;
    acc_pend_d          = (state_q == S_ACC_RD);
    core_rst_d          = 1'b0;
    out_valid_d         = 1'b0;
    out_idx_d           = '0;
    busy_d              = (state_q != S_IDLE) && (state_q != S_FIN);
    done_d              = (state_q == S_FIN);
    case (state_q)
      S_CLR, S_ACC_RST: core_rst_d = 1'b1;
      S_WL0: begin
        inst_d[B_CEN_X]            = 1'b0;
        inst_d[B_L0_WR]            = 1'b1;
        inst_d[B_A_XMEM +: ADDR_W] = ADDR_W'(W_BASE)
                                   + ADDR_W'(kij_q) * ADDR_W'(COL)
                                   + ADDR_W'(cnt_q);
      end
      S_WPE: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_LOAD]  = 1'b1;
      end
      S_AL0: begin
        inst_d[B_CEN_X]            = 1'b0;
        inst_d[B_L0_WR]            = 1'b1;
        inst_d[B_A_XMEM +: ADDR_W] = ADDR_W'(cnt_q);
      end
      S_EXE: begin
        inst_d[B_L0_RD]   = 1'b1;
        inst_d[B_EXECUTE] = (cnt_q < CNT_W'(LEN_NIJ));
      end
      S_DRN: begin
        inst_d[B_OFIFO_RD] = core_if.valid;
        if (core_if.valid) begin
          inst_d[B_CEN_P]            = 1'b0;
          inst_d[B_WEN_P]            = 1'b0;
          inst_d[B_A_PMEM +: ADDR_W] = ADDR_W'(kij_q) * ADDR_W'(LEN_NIJ)
                                     + ADDR_W'(cnt_q);
        end
      end
      S_ACC_RD: begin
        inst_d[B_CEN_P]            = 1'b0;
        inst_d[B_A_PMEM +: ADDR_W] = acc_addr_c;
      end
      S_ACC_OUT: if (cnt_q == CNT_W'(1)) begin
        out_valid_d = 1'b1;
        out_idx_d   = o_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      cnt_q       <= '0;
      kij_q       <= '0;
      o_q         <= '0;
      acc_pend_q  <= 1'b0;
      inst_q      <= INST_IDLE;
      core_rst_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      kij_q       <= kij_d;
      o_q         <= o_d;
      acc_pend_q  <= acc_pend_d;
      inst_q      <= inst_d;
      core_rst_q  <= core_rst_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  // Cleared on start accept, counts busy cycles, holds after done.
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (start_acc_c) begin
      perf_d = '0;
    end else if (busy_q) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

  assign core_if.inst     = inst_q;
  assign core_if.core_rst = core_rst_q;
  assign out_valid        = out_valid_q;
  assign out_idx          = out_idx_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_core_inst_sequencer.sv
`timescale 1ns/1ps
module tb_core_inst_sequencer;

  localparam int BUDGET = 5000;
  localparam logic [34:0] IDLE_PAT = 35'h1800C0000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       out_valid;
  logic [4:0] out_idx;
  logic       busy;
  logic       done;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  core_inst_sequencer_if bus ();

  core_inst_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .core_if   (bus),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
`ifdef SEQ_PERF_CNT_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt;
  int done_cnt;
  logic prev_valid, prev_read, prev_acc;

  // One clock: remember pre-edge view, sample #1 after edge, toggle valid.
  task automatic step();
    prev_valid = bus.valid;
    prev_read  = (bus.inst[32] === 1'b0) && (bus.inst[31] === 1'b1);
    prev_acc   = bus.inst[33];
    @(posedge clk);
    #1;
    bus.valid = ~bus.valid;
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic do_start();
    busy_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bus.valid = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_cmp++;
    if (bus.inst !== IDLE_PAT) begin
      n_bad++; $display("FAIL reset_inst: got %h want %h", bus.inst, IDLE_PAT);
    end
    n_cmp++;
    if ({bus.core_rst, busy, done, out_valid, out_idx} !== 9'd0) begin
      n_bad++; $display("FAIL reset_ctrl: core_rst=%b busy=%b done=%b out_valid=%b out_idx=%0d want all 0",
                        bus.core_rst, busy, done, out_valid, out_idx);
    end
`ifdef SEQ_PERF_CNT_EN
    n_cmp++;
    if (perf_cycles !== 32'd0) begin
      n_bad++; $display("FAIL reset_perf: got %0d want 0", perf_cycles);
    end
`endif
  endtask

  task automatic test_weight_addr();
    int unsigned exp_q[$];
    int unsigned e;
    bit got_done = 0;
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(32'h400 + k * 8 + i);
      for (int n = 0; n < 36; n++) exp_q.push_back(n);
    end
    do_start();
    for (int c = 0; c < BUDGET; c++) begin
      step();
      if (bus.inst[2] === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL xmem_extra: got A_xmem=%h want no l0_wr", bus.inst[17:7]);
        end else begin
          e = exp_q.pop_front();
          if (bus.inst[17:7] !== 11'(e) || bus.inst[19] !== 1'b0) begin
            n_bad++; $display("FAIL xmem_addr: got A=%h CEN=%b want A=%h CEN=0",
                              bus.inst[17:7], bus.inst[19], 11'(e));
          end
        end
      end
      if (done === 1'b1) begin got_done = 1; break; end
    end
    n_cmp++;
    if (!got_done || exp_q.size() != 0) begin
      n_bad++; $display("FAIL xmem_end: got done=%0d left=%0d want done=1 left=0", got_done, exp_q.size());
    end
  endtask

  task automatic test_exec_window();
    int ex_q[$];
    int l0_q[$];
    int ex_run = 0, l0_run = 0, ld_run = 0;
    int e;
    bit got_done = 0;
    for (int k = 0; k < 9; k++) begin
      ex_q.push_back(36);
      l0_q.push_back(8);
      l0_q.push_back(52);
    end
    do_start();
    for (int c = 0; c < BUDGET; c++) begin
      step();
      if (bus.inst[1] === 1'b1) ex_run++;
      else if (ex_run > 0) begin
        n_cmp++;
        e = (ex_q.size() > 0) ? ex_q.pop_front() : -1;
        if (ex_run != e) begin
          n_bad++; $display("FAIL exe_len: got %0d want %0d", ex_run, e);
        end
        ex_run = 0;
      end
      if (bus.inst[3] === 1'b1) l0_run++;
      else if (l0_run > 0) begin
        n_cmp++;
        e = (l0_q.size() > 0) ? l0_q.pop_front() : -1;
        if (l0_run != e) begin
          n_bad++; $display("FAIL l0_rd_len: got %0d want %0d", l0_run, e);
        end
        l0_run = 0;
      end
      if (bus.inst[0] === 1'b1) ld_run++;
      else if (ld_run > 0) begin
        n_cmp++;
        if (ld_run != 8) begin
          n_bad++; $display("FAIL load_len: got %0d want 8", ld_run);
        end
        ld_run = 0;
      end
      if (done === 1'b1) begin got_done = 1; break; end
    end
    n_cmp++;
    if (!got_done || ex_q.size() != 0 || l0_q.size() != 0) begin
      n_bad++; $display("FAIL exe_end: got done=%0d ex_left=%0d l0_left=%0d want 1/0/0",
                        got_done, ex_q.size(), l0_q.size());
    end
  endtask

  task automatic test_drain();
    int unsigned exp_q[$];
    int unsigned e;
    bit got_done = 0;
    for (int k = 0; k < 9; k++)
      for (int n = 0; n < 36; n++) exp_q.push_back(k * 36 + n);
    do_start();
    for (int c = 0; c < BUDGET; c++) begin
      step();
      if (bus.inst[32] === 1'b0 && bus.inst[31] === 1'b0) begin
        n_cmp++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h7ff;
        if (bus.inst[30:20] !== 11'(e) || bus.inst[6] !== 1'b1 || prev_valid !== 1'b1) begin
          n_bad++; $display("FAIL pmem_wr: got A=%0d ofifo_rd=%b valid_before=%b want A=%0d ofifo_rd=1 valid_before=1",
                            bus.inst[30:20], bus.inst[6], prev_valid, e);
        end
      end
      if (bus.inst[6] === 1'b1) begin
        n_cmp++;
        if (prev_valid !== 1'b1) begin
          n_bad++; $display("FAIL ofifo_rd: got ofifo_rd=1 with valid_before=%b want valid_before=1", prev_valid);
        end
      end
      if (done === 1'b1) begin got_done = 1; break; end
    end
    n_cmp++;
    if (!got_done || exp_q.size() != 0) begin
      n_bad++; $display("FAIL drain_end: got done=%0d left=%0d want done=1 left=0", got_done, exp_q.size());
    end
  endtask

  task automatic test_accumulate();
    int unsigned rd_q[$];
    int unsigned idx_q[$];
    int unsigned e;
    int acc_run = 0;
    bit got_done = 0;
    for (int o = 0; o < 16; o++) begin
      idx_q.push_back(o);
      for (int k = 0; k < 9; k++)
        rd_q.push_back(k * 36 + (o / 4 + k / 3) * 6 + o % 4 + k % 3);
    end
    do_start();
    for (int c = 0; c < BUDGET; c++) begin
      step();
      if (bus.inst[32] === 1'b0 && bus.inst[31] === 1'b1) begin
        n_cmp++;
        e = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h7ff;
        if (bus.inst[30:20] !== 11'(e)) begin
          n_bad++; $display("FAIL acc_rd_addr: got %0d want %0d", bus.inst[30:20], e);
        end
      end
      if (bus.inst[33] === 1'b1 || prev_read) begin
        n_cmp++;
        if (bus.inst[33] !== prev_read) begin
          n_bad++; $display("FAIL acc_align: got acc=%b want %b", bus.inst[33], prev_read);
        end
      end
      if (bus.inst[33] === 1'b1) acc_run++;
      else if (acc_run > 0) begin
        n_cmp++;
        if (acc_run != 9) begin
          n_bad++; $display("FAIL acc_len: got %0d want 9", acc_run);
        end
        acc_run = 0;
      end
      if (out_valid === 1'b1) begin
        n_cmp++;
        e = (idx_q.size() > 0) ? idx_q.pop_front() : 32'd31;
        if (out_idx !== 5'(e) || prev_acc !== 1'b1 || bus.inst[33] !== 1'b0) begin
          n_bad++; $display("FAIL out_idx: got idx=%0d acc_before=%b acc=%b want idx=%0d acc_before=1 acc=0",
                            out_idx, prev_acc, bus.inst[33], e);
        end
      end
      if (done === 1'b1) begin got_done = 1; break; end
    end
    n_cmp++;
    if (!got_done || rd_q.size() != 0 || idx_q.size() != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL acc_end: got done=%0d rd_left=%0d idx_left=%0d busy=%b want 1/0/0/0",
                        got_done, rd_q.size(), idx_q.size(), busy);
    end
  endtask

  task automatic test_abort();
    int exe_rises = 0;
    logic prev_exe = 1'b0;
    bit hit = 0, got_done = 0, first_seen = 0;
    do_start();
    for (int c = 0; c < BUDGET; c++) begin
      step();
      if (bus.inst[1] === 1'b1 && prev_exe === 1'b0) exe_rises++;
      prev_exe = bus.inst[1];
      if (exe_rises == 4) begin hit = 1; break; end
    end
    n_cmp++;
    if (!hit) begin
      n_bad++; $display("FAIL abort_reach: got %0d execute bursts want 4", exe_rises);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (bus.inst !== IDLE_PAT || busy !== 1'b0 || bus.core_rst !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle: got inst=%h busy=%b core_rst=%b want %h 0 0",
                        bus.inst, busy, bus.core_rst, IDLE_PAT);
    end
    done_cnt = 0;
    for (int c = 0; c < 20; c++) step();
    n_cmp++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_quiet: got done=%0d busy=%b want 0 0", done_cnt, busy);
    end
    do_start();
    for (int c = 0; c < BUDGET; c++) begin
      step();
      if (!first_seen && bus.inst[2] === 1'b1) begin
        first_seen = 1;
        n_cmp++;
        if (bus.inst[17:7] !== 11'h400) begin
          n_bad++; $display("FAIL rerun_first: got A_xmem=%h want 400", bus.inst[17:7]);
        end
      end
      if (done === 1'b1) begin got_done = 1; break; end
    end
    n_cmp++;
    if (!got_done || done_cnt != 1 || !first_seen) begin
      n_bad++; $display("FAIL rerun_done: got done=%0d pulses=%0d first=%0d want 1 1 1",
                        got_done, done_cnt, first_seen);
    end
  endtask

  task automatic test_start_ignored();
    int w_cnt = 0;
    bit got_done = 0, busy_gap = 0;
    do_start();
    for (int c = 0; c < BUDGET; c++) begin
      start = (c == 100 || c == 600 || c == 1500) ? 1'b1 : 1'b0;
      step();
      if (bus.inst[2] === 1'b1 && bus.inst[17:7] >= 11'h400) w_cnt++;
      if (c > 0 && done !== 1'b1 && busy !== 1'b1) busy_gap = 1;
      if (done === 1'b1) begin got_done = 1; break; end
    end
    start = 1'b0;
    n_cmp++;
    if (!got_done || w_cnt != 72 || busy_gap) begin
      n_bad++; $display("FAIL start_ignored: got done=%0d weights=%0d busy_gap=%0d want 1 72 0",
                        got_done, w_cnt, busy_gap);
    end
`ifdef SEQ_PERF_CNT_EN
    n_cmp++;
    if (perf_cycles !== 32'(busy_cnt)) begin
      n_bad++; $display("FAIL perf_cycles: got %0d want %0d", perf_cycles, busy_cnt);
    end
`endif
    for (int c = 0; c < 10; c++) step();
    n_cmp++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      n_bad++; $display("FAIL post_done: got busy=%b done_pulses=%0d want 0 1", busy, done_cnt);
    end
`ifdef SEQ_PERF_CNT_EN
    n_cmp++;
    if (perf_cycles !== 32'(busy_cnt)) begin
      n_bad++; $display("FAIL perf_hold: got %0d want %0d", perf_cycles, busy_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_weight_addr();
    test_exec_window();
    test_drain();
    test_accumulate();
    test_abort();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
